// File: rtl/present_la_sequencer_pkg.sv
// rtl/present_la_sequencer_pkg.sv - shared types and constants for the PRESENT LA sequencer
package present_pkg;

  localparam int KEY_W_DEF = 80;
  localparam int BLK_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] ADDR_KEY0 = 3'd0;
  localparam logic [2:0] ADDR_KEY1 = 3'd1;
  localparam logic [2:0] ADDR_KEY2 = 3'd2;
  localparam logic [2:0] ADDR_PT0  = 3'd3;
  localparam logic [2:0] ADDR_PT1  = 3'd4;
  localparam logic [2:0] ADDR_CTRL = 3'd7;

  localparam logic [1:0] RD_CT_LO  = 2'd0;
  localparam logic [1:0] RD_CT_HI  = 2'd1;
  localparam logic [1:0] RD_STATUS = 2'd2;
  localparam logic [1:0] RD_DBG    = 2'd3;

  localparam int STAT_BUSY    = 31;
  localparam int STAT_DONE    = 30;
  localparam int STAT_TIMEOUT = 29;
  localparam int STAT_ERR     = 28;

  localparam int CMD_WR_BIT    = 35;
  localparam int CMD_START_BIT = 36;

endpackage

// File: rtl/present_la_sequencer_edge_det.sv
// rtl/present_la_sequencer_edge_det.sv - single-bit rising-edge detector
module la_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  // Level held high yields exactly one pulse, on the first cycle it is seen.
  assign pulse = din & ~din_q;

endmodule

// File: rtl/present_la_sequencer.sv
// rtl/present_la_sequencer.sv - LA command decode, key/pt assembly and launch/timeout sequencing
module present_la_sequencer
  import present_pkg::*;
#(
  parameter int KEY_W       = KEY_W_DEF,
  parameter int BLK_W       = BLK_W_DEF,
  parameter int TIMEOUT_CYC = 63,
  parameter int CNT_W       = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [38:0]       la_data_in,
  output logic [31:0]       la_data_out,
  output logic [KEY_W-1:0]  core_key,
  output logic [BLK_W-1:0]  core_pt,
  output logic              core_start,
  input  logic              core_done,
  input  logic [BLK_W-1:0]  core_ct,
  output logic              busy
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYC);

  logic [31:0]       cmd_data;
  logic [2:0]        cmd_addr;
  logic [1:0]        rd_sel;
  logic              wr_evt;
  logic              start_evt;

  state_t            state;
  state_t            state_nxt;
  logic [TCNT_W-1:0] tcnt;
  logic [KEY_W-1:0]  key_q;
  logic [BLK_W-1:0]  pt_q;
  logic [BLK_W-1:0]  ct_q;
  logic [CNT_W-1:0]  op_cnt;
  logic              done_q;
  logic              timeout_q;
  logic              err_q;

  logic              op_done;
  logic              op_timeout;
  logic              launch;
  logic              err_set;
  logic              err_clr;
  logic              bad_addr;
  logic [CNT_W+15:0] op_cnt_ext;
  logic [15:0]       op_cnt_rd;
  logic [31:0]       rd_word;

  assign cmd_data = la_data_in[31:0];
  assign cmd_addr = la_data_in[34:32];
  assign rd_sel   = la_data_in[38:37];

  la_edge_det u_wr_edge (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .din   (la_data_in[CMD_WR_BIT]),
    .pulse (wr_evt)
  );

  la_edge_det u_start_edge (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .din   (la_data_in[CMD_START_BIT]),
    .pulse (start_evt)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_evt) begin
          state_nxt = START;
        end
      end
      START: begin
        core_start = 1'b1;
        busy       = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (core_done || tcnt == TCNT_MAX) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A completion landing on the last timeout cycle counts as done, not timeout.
  assign op_done    = (state == WAIT) && core_done;
  assign op_timeout = (state == WAIT) && !core_done && (tcnt == TCNT_MAX);
  assign launch     = start_evt && !busy;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tcnt <= '0;
    end else if (state == START) begin
      tcnt <= '0;
    end else if (state == WAIT) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Key/pt only change outside START/WAIT, so the core sees them stable.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      key_q <= '0;
      pt_q  <= '0;
    end else if (wr_evt && !busy) begin
      case (cmd_addr)
        ADDR_KEY0: key_q[31:0]  <= cmd_data;
        ADDR_KEY1: key_q[63:32] <= cmd_data;
        ADDR_KEY2: key_q[79:64] <= cmd_data[15:0];
        ADDR_PT0:  pt_q[31:0]   <= cmd_data;
        ADDR_PT1:  pt_q[63:32]  <= cmd_data;
        default: ;
      endcase
    end
  end

  assign bad_addr = (cmd_addr > ADDR_PT1) &&
                    !((cmd_addr == ADDR_CTRL) && cmd_data[0]);
  assign err_set  = (wr_evt && (busy || bad_addr)) || (start_evt && busy);
  assign err_clr  = wr_evt && !busy && (cmd_addr == ADDR_CTRL) && cmd_data[0];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      ct_q      <= '0;
      op_cnt    <= '0;
    end else if (launch) begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (op_done) begin
      done_q    <= 1'b1;
      ct_q      <= core_ct;
      op_cnt    <= op_cnt + 1'b1;
    end else if (op_timeout) begin
      timeout_q <= 1'b1;
    end
  end

  assign op_cnt_ext = {16'b0, op_cnt};
  assign op_cnt_rd  = op_cnt_ext[15:0];

  always_comb begin
    rd_word = '0;
    case (rd_sel)
      RD_CT_LO:  rd_word = ct_q[31:0];
      RD_CT_HI:  rd_word = ct_q[63:32];
      RD_STATUS: rd_word = {busy, done_q, timeout_q, err_q, 12'b0, op_cnt_rd};
      RD_DBG:    rd_word = {13'b0, state, 1'b0, key_q[79:64]};
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      la_data_out <= '0;
    end else begin
      la_data_out <= rd_word;
    end
  end

  assign core_key = key_q;
  assign core_pt  = pt_q;

endmodule

// File: doc/present_la_sequencer.md
Name: present_la_sequencer

Overview:
- Upstream command/sequencing stage for the PRESENT-80 core inside the user project.
- Decodes the 39-bit logic-analyzer command word from the management SoC.
- Assembles the 80-bit key and 64-bit plaintext, launches one encryption, and waits for completion with a timeout.
- Captures the 64-bit ciphertext and returns it, or status, over the 32-bit LA readback bus.

Parameters:
- KEY_W, 80, key width presented to the core.
- BLK_W, 64, block width (plaintext and ciphertext).
- TIMEOUT_CYC, 63, maximum cycles from core_start to core_done before the operation is aborted.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- la_data_in  in  39  command word: [31:0] data, [34:32] addr, [35] wr, [36] start, [38:37] rd_sel.
- la_data_out  out  32  readback word selected by rd_sel.
- core_key  out  80  key to the core; held stable while busy.
- core_pt  out  64  plaintext to the core; held stable while busy.
- core_start  out  1  single-cycle launch pulse.
- core_done  in  1  single-cycle completion pulse from the core.
- core_ct  in  64  ciphertext; valid in the cycle core_done=1.
- busy  out  1  high in START and WAIT states.

Behaviour:
- Reset (async assert, sync release):
  - key, pt, ct capture and op counter = 0.
  - State = IDLE.
  - core_start = 0, busy = 0, la_data_out = 0.
  - Sticky flags (done, timeout, err) = 0.
- Edge detection: la_data_in[35] and [36] are registered once. Rising edges (current=1, previous=0) produce internal wr_evt and start_evt. Holding a bit high produces exactly one event.
- Write decode on wr_evt, using data=[31:0] and addr=[34:32]:
  - 0 → key[31:0].
  - 1 → key[63:32].
  - 2 → key[79:64] from data[15:0]; data[31:16] ignored.
  - 3 → pt[31:0].
  - 4 → pt[63:32].
  - 5–7: no register write; set err.
  - Any wr_evt while busy=1: write dropped, err set.
- FSM, states IDLE, START, WAIT, DONE:
  - IDLE/DONE + start_evt → START.
    - Clears the done and timeout flags; err is preserved.
    - start_evt in START/WAIT is ignored and sets err.
  - START: core_start=1 for exactly this one cycle; timeout counter loaded to 0 → WAIT.
  - WAIT: counter increments each cycle.
    - core_done=1 → capture core_ct, set done, increment op counter (wraps mod 2^CNT_W) → DONE.
    - Else if counter == TIMEOUT_CYC → set timeout, ct unchanged → DONE.
    - core_done and the timeout compare in the same cycle: done wins.
  - DONE: idle-equivalent; holds flags and ct.
- Simultaneous wr_evt and start_evt in IDLE/DONE: the write commits in that cycle. core_start is issued the following cycle with the updated key/pt, so the new value is used.
- Readback: la_data_out is registered, one cycle latency from an rd_sel change.
  - rd_sel 0 → ct[31:0].
  - rd_sel 1 → ct[63:32].
  - rd_sel 2 → {busy, done, timeout, err, 12'b0, op_cnt[15:0]}; field positions assume CNT_W=16.
  - rd_sel 3 → {13'b0, state[1:0] encoding, 1'b0, key[79:64]}.
- err clear: err is cleared only by reset, or by a write to addr 7 with data[0]=1. This write is the one exception to the addr 5–7 rule: it clears err and does not set it.
- core_done outside WAIT: ignored.
- Reset mid-WAIT: immediate return to IDLE, all outputs at reset values; any later core_done is ignored.

Decomposition:
- Shared package present_pkg holds:
  - State enum (IDLE=0, START=1, WAIT=2, DONE=3).
  - Address constants ADDR_KEY0..ADDR_PT1 and ADDR_CTRL=7.
  - Readback select constants RD_CT_LO, RD_CT_HI, RD_STATUS, RD_DBG.
  - Status bit indices.
  - KEY_W and BLK_W defaults.
- One natural sub-module: la_edge_det, a rising-edge detector instantiated for the wr and start bits.
- Everything else stays in present_la_sequencer.

Test Plan:
- Reset mid-operation: assert wb_rst_i asynchronously during WAIT → la_data_out=0, core_start=0, busy=0 with no clock edge. After release, rd_sel=2 reads 0x00000000.
- Known vector: write key all zeros, pt all zeros, pulse start; model core returns core_ct=64'h5579C1387B228445 after 32 cycles.
  - core_start high exactly one cycle.
  - rd_sel=0 → 0x7B228445; rd_sel=1 → 0x5579C138.
  - Status reads done=1, op_cnt=1.
- Key/pt assembly: write addr0=0x01234567, addr1=0x89ABCDEF, addr2=0xFFFF1122, addr3=0xDEADBEEF, addr4=0xCAFEF00D → core_key=80'h112289ABCDEF01234567 and core_pt=64'hCAFEF00DDEADBEEF at core_start.
- Timeout: model never asserts core_done → exactly TIMEOUT_CYC+1 cycles after core_start, status reads timeout=1, done=0, busy=0; ct unchanged, op_cnt unchanged.
- Protocol errors:
  - wr to addr 3 while busy → pt unchanged, err=1.
  - start while busy → no second core_start.
  - wr addr7 data=1 → err=0.
  - wr bit held high 10 cycles → single write.
- Boundaries:
  - core_done in the same cycle the counter hits TIMEOUT_CYC → done=1, timeout=0.
  - wr and start rising together → the new pt is used.
  - op_cnt preloaded by 65535 operations, or forced in sim → wraps to 0.
